// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_mem_slave
// Description : APB completer backed by a DEPTH-word register memory, with a
//               fixed number of PREADY-low wait states on every transfer.
//               Optional error response is enabled by defining the macro
//               APB_SLV_ERR_EN (adds the PSLVERR port and address checking).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY
`ifdef APB_SLV_ERR_EN
    ,
    output logic                  PSLVERR
`endif
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = 4;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                  state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic                    write_q,  write_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    w_setup;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_addr_err;
    logic                    w_xfer_err;
    logic                    w_mem_we;

    // Bus decode: setup phase detection and word index extraction
    assign w_setup = PSEL && !PENABLE;
    assign w_idx   = PADDR[ADDR_LSB +: IDX_W];

`ifdef APB_SLV_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK  = ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIM = ADDR_WIDTH'(DEPTH);

    logic err_q, err_d;

    // Misaligned or out-of-range byte address flags an error at setup
    assign w_addr_err = ((PADDR & LSB_MASK) != '0) || ((PADDR >> ADDR_LSB) >= DEPTH_LIM);
    assign w_xfer_err = err_q;

    // Error flag is captured with the address and held for the whole transfer
    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && w_setup) begin
            err_d = w_addr_err;
        end
    end

    // Error flag register
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Error response is visible only in the completing cycle; read data is
    // forced to zero there, while the held read register stays untouched
    assign PSLVERR = PREADY && err_q;
    assign PRDATA  = (PREADY && err_q) ? '0 : prdata_q;
`else
    logic w_unused_addr;

    // Upper and byte-offset address bits have no meaning without checking
    assign w_unused_addr = ^PADDR;
    assign w_addr_err    = 1'b0;
    assign w_xfer_err    = 1'b0;
    assign PRDATA        = prdata_q;
`endif

    // Ready is a pure function of registered state
    assign PREADY = (state_q == S_ACCESS) && (cnt_q == '0);

    // Next-state logic for the IDLE/ACCESS handshake and read data capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        prdata_d = prdata_q;
        w_mem_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                // An enable without a preceding setup is not a transfer
                if (w_setup) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    idx_d   = w_idx;
                    write_d = PWRITE;
                    if (!PWRITE && !w_addr_err) begin
                        prdata_d = mem_q[w_idx];
                    end
                end
            end
            S_ACCESS: begin
                if (!PSEL || !PENABLE) begin
                    // Master abandoned the transfer: drop it silently
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d  = S_IDLE;
                    w_mem_we = write_q && !w_xfer_err;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and read-data registers
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            prdata_q <= prdata_d;
        end
    end

    // Word memory: cleared by reset, written only on a good write completion
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_mem_we) begin
            mem_q[idx_q] <= PWDATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_mem_slave
// Description : Directed bench for apb_mem_slave; one zero-wait instance and
//               one three-wait-state instance share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_mem_slave;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] rd;
    logic        er;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
        .PCLK     (clk),
        .PRESET_N (rst_n),
        .PSEL     (psel[0]),
        .PENABLE  (penable[0]),
        .PWRITE   (pwrite[0]),
        .PADDR    (paddr[0]),
        .PWDATA   (pwdata[0]),
        .PRDATA   (prdata[0]),
        .PREADY   (pready[0])
`ifdef APB_SLV_ERR_EN
        ,
        .PSLVERR  (pslverr[0])
`endif
    );

    apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(3)) u_dut3 (
        .PCLK     (clk),
        .PRESET_N (rst_n),
        .PSEL     (psel[1]),
        .PENABLE  (penable[1]),
        .PWRITE   (pwrite[1]),
        .PADDR    (paddr[1]),
        .PWDATA   (pwdata[1]),
        .PRDATA   (prdata[1]),
        .PREADY   (pready[1])
`ifdef APB_SLV_ERR_EN
        ,
        .PSLVERR  (pslverr[1])
`endif
    );

`ifndef APB_SLV_ERR_EN
    assign pslverr[0] = 1'b0;
    assign pslverr[1] = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the completion edge
    // with the bus still in its access phase.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ws, input string tag,
                        output logic [31:0] rdata, output logic err);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        for (int i = 0; i < ws; i++) begin
            @(negedge clk);
            check({tag, "_wait"}, {31'd0, pready[d]}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, pready[d]}, 32'd1);
        rdata = prdata[d];
        err   = pslverr[d];
        @(posedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready0", {31'd0, pready[0]}, 32'd0);
        check("rst_prdata0", prdata[0], 32'd0);
        check("rst_pready3", {31'd0, pready[1]}, 32'd0);
        check("rst_pslverr0", {31'd0, pslverr[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait read of a cleared word
        xfer(0, 1'b0, 32'h0, 32'h0, 0, "rd0", rd, er);
        check("rd0_data", rd, 32'h0);
        bus_idle(0);
        @(posedge clk); #1;

        // Write then back-to-back read of the same word
        xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 0, "wr8", rd, er);
        check("wr8_prdata_held", rd, 32'h0);
        xfer(0, 1'b0, 32'h8, 32'h0, 0, "rd8", rd, er);
        check("rd8_data", rd, 32'hDEADBEEF);
        check("rd8_err", {31'd0, er}, 32'd0);
        bus_idle(0);
        @(negedge clk);
        check("rd8_hold_idle", prdata[0], 32'hDEADBEEF);
        check("idle_pready", {31'd0, pready[0]}, 32'd0);
        @(posedge clk); #1;

        // Enable without setup must be ignored
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h0;
        @(negedge clk);
        check("nosetup_pready", {31'd0, pready[0]}, 32'd0);
        @(posedge clk); #1;
        bus_idle(0);

        // Three wait states on a write, then read it back
        xfer(1, 1'b1, 32'h4, 32'hCAFE0001, 3, "ws_wr4", rd, er);
        bus_idle(1);
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h4, 32'h0, 3, "ws_rd4", rd, er);
        check("ws_rd4_data", rd, 32'hCAFE0001);
        bus_idle(1);
        @(posedge clk); #1;

        // Abort a wait-stated write to 0xC by dropping PSEL
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'hC; pwdata[1] = 32'h12345678;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        bus_idle(1);
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'hC, 32'h0, 3, "abort_rdC", rd, er);
        check("abort_rdC_data", rd, 32'h0);
        bus_idle(1);
        @(posedge clk); #1;

        // Out-of-range address: error response or modulo-DEPTH wrap
        xfer(0, 1'b1, 32'h0, 32'h00000077, 0, "wr0", rd, er);
        bus_idle(0);
        @(posedge clk); #1;
`ifdef APB_SLV_ERR_EN
        xfer(0, 1'b1, 32'h40, 32'h00000011, 0, "err_wr40", rd, er);
        check("err_wr40_slverr", {31'd0, er}, 32'd1);
        check("err_wr40_prdata", rd, 32'h0);
        bus_idle(0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h0, 32'h0, 0, "err_rd0", rd, er);
        check("err_rd0_data", rd, 32'h00000077);
        check("err_rd0_slverr", {31'd0, er}, 32'd0);
        bus_idle(0);
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h6, 32'h0, 3, "err_mis6", rd, er);
        check("err_mis6_slverr", {31'd0, er}, 32'd1);
        bus_idle(1);
        @(posedge clk); #1;
`else
        xfer(0, 1'b1, 32'h40, 32'h00000011, 0, "wrap_wr40", rd, er);
        bus_idle(0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h0, 32'h0, 0, "wrap_rd0", rd, er);
        check("wrap_rd0_data", rd, 32'h00000011);
        bus_idle(0);
        @(posedge clk); #1;
`endif

        // Reset asserted while a zero-wait write sits in its access cycle
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h4; pwdata[0] = 32'h00005A5A;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        #1;
        check("midrst_pre_pready", {31'd0, pready[0]}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_pready", {31'd0, pready[0]}, 32'd0);
        @(posedge clk); #1;
        bus_idle(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h4, 32'h0, 0, "midrst_rd4", rd, er);
        check("midrst_rd4_data", rd, 32'h0);
        xfer(0, 1'b0, 32'h8, 32'h0, 0, "midrst_rd8", rd, er);
        check("midrst_rd8_data", rd, 32'h0);
        bus_idle(0);
        xfer(1, 1'b0, 32'h4, 32'h0, 3, "midrst_ws_rd4", rd, er);
        check("midrst_ws_rd4_data", rd, 32'h0);
        bus_idle(1);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
